uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_rx.sv | 236 +++++++++++++++++++++++
 tb/tb_uart_rx.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx -- oversampling UART receiver
//
// Purpose:
//   Receives asynchronous serial frames (start bit, DBIT data bits LSB first,
//   optional even parity bit, stop bit(s)) using a 16x oversample strobe from
//   an external baud generator. The start bit is confirmed at its middle,
//   and every later bit is sampled 16 ticks after the previous sample point,
//   which is again the middle of that bit.
//
// Parameters:
//   DBIT     data bits per frame (5..8)
//   SB_TICK  oversample ticks spent in the stop bit (16 = 1, 24 = 1.5, 32 = 2)
//
// Ports:
//   clk           system clock, all state changes on its rising edge
//   rst_n         asynchronous active-low reset
//   rx            serial line, asynchronous to clk, idle high
//   s_tick        one-clk oversample strobe, 16 per bit period
//   dout          last received data word
//   rx_done_tick  one-clk pulse when a frame completes (with or without errors)
//   frame_err     stop bit was sampled low on the last completed frame
//   parity_err    parity mismatch on the last completed frame
//
// Configuration:
//   UART_RX_PARITY_EN  when defined, a PARITY state checks one even-parity
//                      bit after the data bits; when undefined, DATA goes
//                      straight to STOP and parity_err is tied low.
// ---------------------------------------------------------------------------
module uart_rx #(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            rx,
    input  logic            s_tick,
    output logic [DBIT-1:0] dout,
    output logic            rx_done_tick,
    output logic            frame_err,
    output logic            parity_err
);

    // Terminal counts, sized to the counters they are compared against.
    // The 5-bit tick counter covers SB_TICK up to 32 (two stop bits).
    localparam logic [4:0] START_LAST = 5'd7;
    localparam logic [4:0] BIT_LAST   = 5'd15;
    localparam logic [4:0] STOP_LAST  = 5'(SB_TICK - 1);
    localparam logic [2:0] DATA_LAST  = 3'(DBIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [4:0]      s;
    logic [4:0]      s_next;
    logic [2:0]      n;
    logic [2:0]      n_next;
    logic [DBIT-1:0] b;
    logic [DBIT-1:0] b_next;
    logic            rx_meta;
    logic            rx_s;

`ifdef UART_RX_PARITY_EN
    logic            par;
    logic            par_next;
`endif

    // Two-flop synchronizer. Both flops reset to the idle (high) level so
    // that a reset never looks like a start edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    // State and datapath registers. Everything here only moves when the
    // next-state logic says so, which in turn only advances on s_tick
    // (except for the IDLE start-edge detection).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            s     <= '0;
            n     <= '0;
            b     <= '0;
        end else begin
            state <= state_next;
            s     <= s_next;
            n     <= n_next;
            b     <= b_next;
        end
    end

`ifdef UART_RX_PARITY_EN
    // Holds the received parity bit until the stop bit is evaluated.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par <= 1'b0;
        end else begin
            par <= par_next;
        end
    end
`endif

    // Result registers: captured only on the completion cycle so they stay
    // stable between frames and describe the most recent frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout      <= '0;
            frame_err <= 1'b0;
        end else if (rx_done_tick) begin
            dout      <= b;
            frame_err <= ~rx_s;
        end
    end

`ifdef UART_RX_PARITY_EN
    // Even parity: the data bits plus the parity bit must XOR to zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            parity_err <= 1'b0;
        end else if (rx_done_tick) begin
            parity_err <= (^b) ^ par;
        end
    end
`else
    assign parity_err = 1'b0;
`endif

    // Next-state and output logic. START waits half a bit to confirm the
    // start level at its middle; later states wait a full bit between
    // samples. A start that is high again at its middle is treated as a
    // glitch and silently dropped.
    always_comb begin
        state_next   = state;
        s_next       = s;
        n_next       = n;
        b_next       = b;
`ifdef UART_RX_PARITY_EN
        par_next     = par;
`endif
        rx_done_tick = 1'b0;

        case (state)
            IDLE: begin
                if (!rx_s) begin
                    state_next = START;
                    s_next     = '0;
                end
            end

            START: begin
                if (s_tick) begin
                    if (s == START_LAST) begin
                        s_next = '0;
                        if (!rx_s) begin
                            state_next = DATA;
                            n_next     = '0;
                        end else begin
                            state_next = IDLE;
                        end
                    end else begin
                        s_next = s + 5'd1;
                    end
                end
            end

            DATA: begin
                if (s_tick) begin
                    if (s == BIT_LAST) begin
                        s_next = '0;
                        b_next = {rx_s, b[DBIT-1:1]};
                        if (n == DATA_LAST) begin
`ifdef UART_RX_PARITY_EN
                            state_next = PARITY;
`else
                            state_next = STOP;
`endif
                        end else begin
                            n_next = n + 3'd1;
                        end
                    end else begin
                        s_next = s + 5'd1;
                    end
                end
            end

`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (s_tick) begin
                    if (s == BIT_LAST) begin
                        s_next     = '0;
                        par_next   = rx_s;
                        state_next = STOP;
                    end else begin
                        s_next = s + 5'd1;
                    end
                end
            end
`endif

            // Leaving STOP goes to IDLE, so the next start edge can only be
            // seen from the following clock, never in the completion cycle.
            STOP: begin
                if (s_tick) begin
                    if (s == STOP_LAST) begin
                        s_next       = '0;
                        state_next   = IDLE;
                        rx_done_tick = 1'b1;
                    end else begin
                        s_next = s + 5'd1;
                    end
                end
            end

            default: begin
                state_next = IDLE;
                s_next     = '0;
                n_next     = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_rx.sv
// ---------------------------------------------------------------------------
// tb_uart_rx -- self-checking bench for uart_rx (DBIT=8, SB_TICK=16)
//
// Drives serial frames onto rx with a bench-generated s_tick, predicts each
// frame's dout / frame_err / parity_err from the bit-level frame contents,
// and compares against the DUT one clock after every rx_done_tick pulse.
// Follows UART_RX_PARITY_EN the same way the RTL does.
// ---------------------------------------------------------------------------
module tb_uart_rx;

    localparam int DBIT = 8;

    logic            clk;
    logic            rst_n;
    logic            rx;
    logic            s_tick;
    logic [DBIT-1:0] dout;
    logic            rx_done_tick;
    logic            frame_err;
    logic            parity_err;

    int compared   = 0;
    int mismatched = 0;
    int pulses     = 0;
    int exp_pulses = 0;
    int tick_div   = 4;

    // One table row: what goes on the line, and what must come out.
    typedef struct {
        logic [7:0] data;
        bit         stop_ok;
        bit         pbit;
        int         gap_ticks;
        logic [7:0] exp_dout;
        bit         exp_ferr;
        bit         exp_perr;
        string      name;
    } vec_t;

    // One scoreboard entry per frame that must produce a pulse.
    typedef struct {
        logic [7:0] dout;
        bit         ferr;
        bit         perr;
        string      name;
    } exp_t;

    exp_t       exp_q[$];
    bit         mon_pending = 1'b0;
    logic [7:0] model_dout  = '0;

    uart_rx #(
        .DBIT    (DBIT),
        .SB_TICK (16)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rx           (rx),
        .s_tick       (s_tick),
        .dout         (dout),
        .rx_done_tick (rx_done_tick),
        .frame_err    (frame_err),
        .parity_err   (parity_err)
    );

    // 100 MHz clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Baud generator stand-in: one-clk s_tick every tick_div clocks. Inputs
    // change 2 ns after the rising edge so they are stable at the negedge.
    initial begin
        int tcnt;
        tcnt   = 0;
        s_tick = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (tcnt >= tick_div - 1) begin
                tcnt   = 0;
                s_tick = 1'b1;
            end else begin
                tcnt   = tcnt + 1;
                s_tick = 1'b0;
            end
        end
    end

    // Single comparison point: counts every check, reports failures.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] required);
        compared = compared + 1;
        if (actual !== required) begin
            mismatched = mismatched + 1;
            $display("[TB] FAIL %s: actual %0h, required %0h", name, actual, required);
        end
    endtask

    // Reference model: a frame's result depends only on its data byte, the
    // level of its stop bit, and (with parity) whether the total count of
    // ones across data and parity bit is odd.
    function automatic exp_t modelFrame(input logic [7:0] data, input bit stop_ok,
                                        input bit pbit, input string name);
        exp_t e;
        e.dout = data;
        e.ferr = !stop_ok;
`ifdef UART_RX_PARITY_EN
        e.perr = (($countones(data) + int'(pbit)) % 2) != 0;
`else
        e.perr = 1'b0;
`endif
        e.name = name;
        return e;
    endfunction

    // Hold the current rx level for a number of oversample ticks.
    task automatic waitTicks(input int ticks);
        repeat (ticks * tick_div) begin
            @(posedge clk);
            #2;
        end
    endtask

    // Put one complete frame on the line. A low stop bit is cut short and
    // followed by a full idle bit so the DUT's false start after it is
    // rejected before the next frame begins.
    task automatic sendFrame(input logic [7:0] data, input bit stop_ok,
                             input bit pbit, input int gap_ticks);
        rx = 1'b0;
        waitTicks(16);
        for (int i = 0; i < DBIT; i++) begin
            rx = data[i];
            waitTicks(16);
        end
`ifdef UART_RX_PARITY_EN
        rx = pbit;
        waitTicks(16);
`endif
        if (stop_ok) begin
            rx = 1'b1;
            waitTicks(16);
        end else begin
            rx = 1'b0;
            waitTicks(12);
            rx = 1'b1;
            waitTicks(16);
        end
        if (gap_ticks > 0) waitTicks(gap_ticks);
    endtask

    // Register the expected result, then transmit.
    task automatic applyStimulus(input logic [7:0] data, input bit stop_ok,
                                 input bit pbit, input int gap_ticks, input exp_t e);
        exp_q.push_back(e);
        exp_pulses = exp_pulses + 1;
        sendFrame(data, stop_ok, pbit, gap_ticks);
    endtask

    // Bounded wait until every expected frame has been seen and checked.
    task automatic waitDrain(input string name);
        int cyc;
        cyc = 0;
        while ((exp_q.size() != 0 || mon_pending) && cyc < 20000) begin
            @(posedge clk);
            #2;
            cyc = cyc + 1;
        end
        if (exp_q.size() != 0 || mon_pending) begin
            checkOutput({name, "_timeout"}, exp_q.size(), 0);
            exp_q.delete();
        end
    endtask

    // Monitor: on each pulse take the next expected frame, check the
    // registered results one clock later, and check the pulse has dropped.
    // dout must otherwise hold the last predicted value.
    initial begin
        exp_t cur;
        forever begin
            @(negedge clk);
            if (rst_n !== 1'b1) begin
                mon_pending = 1'b0;
                model_dout  = '0;
            end else begin
                if (mon_pending) begin
                    checkOutput({cur.name, "_dout"}, dout, cur.dout);
                    checkOutput({cur.name, "_frame_err"}, frame_err, cur.ferr);
                    checkOutput({cur.name, "_parity_err"}, parity_err, cur.perr);
                    checkOutput({cur.name, "_pulse_width"}, rx_done_tick, 0);
                    model_dout  = cur.dout;
                    mon_pending = 1'b0;
                end else if (dout !== model_dout) begin
                    checkOutput("dout_hold", dout, model_dout);
                    model_dout = dout;
                end
                if (rx_done_tick === 1'b1) begin
                    pulses = pulses + 1;
                    if (exp_q.size() == 0) begin
                        checkOutput("unexpected_pulse", rx_done_tick, 0);
                    end else begin
                        cur         = exp_q.pop_front();
                        mon_pending = 1'b1;
                    end
                end
            end
        end
    end

    // Hang guard.
    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: actual timeout, required completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched + 1);
        $fatal(1, "[TB] watchdog expired");
    end

    // Main test sequence.
    initial begin
        vec_t vecs[$];
        exp_t e;
        int   p0;
        bit   exp_perr_eff;

        rx    = 1'b1;
        rst_n = 1'b1;

        // Reset asserted before any clock edge: outputs must clear at once.
        #1 rst_n = 1'b0;
        #1;
        checkOutput("reset_dout", dout, 0);
        checkOutput("reset_done", rx_done_tick, 0);
        checkOutput("reset_frame_err", frame_err, 0);
        checkOutput("reset_parity_err", parity_err, 0);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;

        // Idle line for 1000 clocks: nothing may happen.
        repeat (1000) begin
            @(posedge clk);
            #2;
        end
        checkOutput("idle_pulses", pulses, 0);
        checkOutput("idle_dout", dout, 0);
        checkOutput("idle_frame_err", frame_err, 0);

        // 0xA5, 8N1 at the slow tick rate.
        tick_div = 54;
        applyStimulus(8'hA5, 1'b1, 1'b0, 16, modelFrame(8'hA5, 1'b1, 1'b0, "a5_slow"));
        waitDrain("a5_slow");
        tick_div = 4;
        waitTicks(16);

        // Directed table: frame error then recovery, parity cases sent
        // back-to-back, and data edge patterns.
        vecs.push_back('{8'h3C, 1'b0, 1'b0, 16, 8'h3C, 1'b1, 1'b0, "3c_stop_low"});
        vecs.push_back('{8'h01, 1'b1, 1'b1, 16, 8'h01, 1'b0, 1'b0, "01_recover"});
        vecs.push_back('{8'h07, 1'b1, 1'b0,  0, 8'h07, 1'b0, 1'b1, "07_par0"});
        vecs.push_back('{8'h07, 1'b1, 1'b1,  0, 8'h07, 1'b0, 1'b0, "07_par1"});
        vecs.push_back('{8'h00, 1'b1, 1'b0,  0, 8'h00, 1'b0, 1'b0, "00_b2b"});
        vecs.push_back('{8'hFF, 1'b1, 1'b0, 16, 8'hFF, 1'b0, 'x,   "ff"});
        vecs.push_back('{8'h80, 1'b1, 1'b1, 16, 8'h80, 1'b0, 1'b0, "80"});
        vecs[5].exp_perr = 1'b0;
        for (int i = 0; i < vecs.size(); i++) begin
`ifdef UART_RX_PARITY_EN
            exp_perr_eff = vecs[i].exp_perr;
`else
            exp_perr_eff = 1'b0;
`endif
            e.dout = vecs[i].exp_dout;
            e.ferr = vecs[i].exp_ferr;
            e.perr = exp_perr_eff;
            e.name = vecs[i].name;
            applyStimulus(vecs[i].data, vecs[i].stop_ok, vecs[i].pbit, vecs[i].gap_ticks, e);
        end
        waitDrain("table");

        // Start glitch of 4 ticks: must be rejected, then 0x55 received.
        p0 = pulses;
        rx = 1'b0;
        waitTicks(4);
        rx = 1'b1;
        waitTicks(32);
        checkOutput("glitch_no_pulse", pulses, p0);
        applyStimulus(8'h55, 1'b1, 1'b1, 16, modelFrame(8'h55, 1'b1, 1'b1, "55_after_glitch"));
        waitDrain("glitch");

        // Reset in the middle of the 4th data bit of 0xFF.
        p0 = pulses;
        rx = 1'b0;
        waitTicks(16);
        rx = 1'b1;
        waitTicks(48 + 8);
        rst_n = 1'b0;
        #1;
        checkOutput("midreset_dout", dout, 0);
        checkOutput("midreset_done", rx_done_tick, 0);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        waitTicks(48);
        checkOutput("midreset_no_pulse", pulses, p0);
        applyStimulus(8'h12, 1'b1, 1'b0, 16, modelFrame(8'h12, 1'b1, 1'b0, "12_after_reset"));
        waitDrain("midreset");

        // Randomized frames against the reference model. A low stop bit
        // already carries its own idle time, so gaps may be zero.
        for (int i = 0; i < 20; i++) begin
            logic [7:0] d;
            bit         sok;
            bit         pb;
            int         gap;
            d   = 8'($urandom_range(0, 255));
            sok = ($urandom_range(0, 4) != 0);
            pb  = 1'($urandom_range(0, 1));
            gap = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 20));
            applyStimulus(d, sok, pb, gap, modelFrame(d, sok, pb, $sformatf("rand%0d", i)));
        end
        waitDrain("random");

        waitTicks(16);
        checkOutput("total_pulses", pulses, exp_pulses);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
